// File: rtl/dct_pkg.sv
// Shared constants and types for the DCT zigzag reorder buffer.
//   DW_DEFAULT : default coefficient width
//   ZZ_ROM     : zigzag position -> row-major raster index
//   ZZ_SHIFT   : per-zigzag-position right shift, used only when ZZ_QUANT_EN is defined
//   rd_state_e : read-side FSM states
package dct_pkg;

    localparam int DW_DEFAULT = 12;

    localparam logic [5:0] ZZ_ROM [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    // Coarser quantisation toward the high-frequency end of the scan.
    localparam logic [2:0] ZZ_SHIFT [64] = '{
        0, 1, 1, 2, 2, 3, 3, 3,
        3, 3, 4, 4, 4, 4, 4, 4,
        4, 5, 5, 5, 5, 5, 5, 5,
        5, 5, 5, 5, 6, 6, 6, 6,
        6, 6, 6, 6, 6, 6, 6, 6,
        6, 6, 6, 7, 7, 7, 7, 7,
        7, 7, 7, 7, 7, 7, 7, 7,
        7, 7, 7, 7, 7, 7, 7, 7
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } rd_state_e;

endpackage

// File: rtl/dct_zz_bank_ram.sv
// Two-bank coefficient store: 128 x DW, one write port, one registered read port.
// The upper address bit selects the bank, the lower six bits the raster index.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable, raddr : read address
//   rdata : registered read data (holds its value while re is low)
module dct_zz_bank_ram
    import dct_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          we,
    input  logic [6:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [6:0]    raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [128];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dct_zigzag_buf.sv
// Ping-pong reorder buffer: accepts 8x8 DCT coefficients in raster order and
// emits each completed block in JPEG zigzag order with a valid/ready handshake.
// Optional build macro: ZZ_QUANT_EN -- when defined, each output coefficient is
// arithmetically right-shifted by a per-position amount, rounded half away from zero.
//   CLK, RST_N : clock, asynchronous active-low reset
//   din, din_vld : raster-order coefficient input (no back-pressure)
//   dout, dout_vld, dout_rdy : zigzag-order output handshake
//   sob, eob : first / last coefficient of a block on dout
//   ovf : sticky flag, a word arrived while both banks were full and was dropped
module dct_zigzag_buf
    import dct_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic          sob,
    output logic          eob,
    output logic          ovf
);

    rd_state_e     state_q, state_d;
    logic [5:0]    wr_cnt_q, wr_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic [1:0]    full_q, full_d;
    logic          rd_bank_q, rd_bank_d;
    logic [5:0]    rd_idx_q, rd_idx_d;
    logic          ovf_q, ovf_d;

    logic          accept;
    logic          release_bank;
    logic [1:0]    full_rel;
    logic [1:0]    full_set;
    logic          wr_en;
    logic          wr_last;
    logic          rd_en;
    logic [6:0]    rd_addr;
    logic [DW-1:0] rd_data;

`ifdef ZZ_QUANT_EN
    // Divide by 2^sh on the magnitude, rounding half away from zero, then restore sign.
    function automatic logic [DW-1:0] zz_quant(input logic [DW-1:0] x, input logic [2:0] sh);
        logic [DW:0] mag;
        logic [DW:0] half;
        logic [DW:0] q;
        mag  = x[DW-1] ? ((DW+1)'(0) - {x[DW-1], x}) : {1'b0, x};
        half = (sh == 3'd0) ? '0 : ((DW+1)'(1) << (sh - 3'd1));
        q    = (mag + half) >> sh;
        q    = x[DW-1] ? ((DW+1)'(0) - q) : q;
        return q[DW-1:0];
    endfunction
`endif

    // Write side. A bank released this cycle is treated as empty before the
    // incoming word is checked, so a same-cycle release and write never drops.
    always_comb begin
        accept       = (state_q == STREAM) && dout_rdy;
        release_bank = accept && (rd_idx_q == 6'd63);
        full_rel     = full_q;
        if (release_bank) begin
            full_rel[rd_bank_q] = 1'b0;
        end
        wr_en    = din_vld && !full_rel[wr_bank_q];
        wr_last  = wr_en && (wr_cnt_q == 6'd63);
        full_set = 2'b00;
        if (wr_last) begin
            full_set[wr_bank_q] = 1'b1;
        end
        full_d    = full_rel | full_set;
        wr_cnt_d  = wr_en ? (wr_cnt_q + 6'd1) : wr_cnt_q;
        wr_bank_d = wr_last ? ~wr_bank_q : wr_bank_q;
        ovf_d     = ovf_q | (din_vld && !wr_en);
    end

    // Read side. full_d is used so a bank completing this cycle is seen
    // immediately, giving a two-cycle latency from the last input word.
    // When the other bank is already full at the index-63 accept, its first
    // read is issued in that same cycle and the FSM stays in STREAM, so
    // consecutive blocks flow without a bubble.
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;
        rd_en     = 1'b0;
        rd_addr   = {rd_bank_q, ZZ_ROM[rd_idx_q]};
        case (state_q)
            IDLE: begin
                if (full_d[rd_bank_q]) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                rd_en   = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    if (rd_idx_q != 6'd63) begin
                        rd_idx_d = rd_idx_q + 6'd1;
                        rd_en    = 1'b1;
                        rd_addr  = {rd_bank_q, ZZ_ROM[rd_idx_q + 6'd1]};
                    end else begin
                        rd_idx_d  = 6'd0;
                        rd_bank_d = ~rd_bank_q;
                        if (full_d[~rd_bank_q]) begin
                            rd_en   = 1'b1;
                            rd_addr = {~rd_bank_q, ZZ_ROM[6'd0]};
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            wr_cnt_q  <= 6'd0;
            wr_bank_q <= 1'b0;
            full_q    <= 2'b00;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= 6'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
            ovf_q     <= ovf_d;
        end
    end

    dct_zz_bank_ram #(.DW(DW)) u_ram (
        .clk   (CLK),
        .we    (wr_en),
        .waddr ({wr_bank_q, wr_cnt_q}),
        .wdata (din),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // The RAM output register is not reset, so dout is forced to zero
    // whenever no coefficient is being presented.
    always_comb begin
        dout_vld = (state_q == STREAM);
        sob      = dout_vld && (rd_idx_q == 6'd0);
        eob      = dout_vld && (rd_idx_q == 6'd63);
        ovf      = ovf_q;
`ifdef ZZ_QUANT_EN
        dout     = dout_vld ? zz_quant(rd_data, ZZ_SHIFT[rd_idx_q]) : '0;
`else
        dout     = dout_vld ? rd_data : '0;
`endif
    end

endmodule
